// File: rtl/dma_bd_start_scheduler.sv
// ---------------------------------------------------------------------------
// dma_bd_start_scheduler
//
// Collects the one-cycle per-descriptor start pulses coming out of the DMA
// control-register block and hands them to the transfer engine one at a
// time. A pending flag per internal buffer descriptor (BD) remembers every
// start that has not been issued yet. A round-robin pointer picks the next
// BD so that no descriptor can starve another.
//
// The engine side uses a request/acknowledge handshake to accept a BD and
// a single-cycle done strobe to report that the BD has finished. The
// scheduler answers each done with a one-cycle completion pulse.
//
// Ports
//   clock          in   clock
//   resetn         in   asynchronous, active-low reset
//   startDMAOp     in   [NUM_INT_BDS]   start pulses, bit n = BD n
//   opReq          out  request to engine: execute BD opBdNum
//   opBdNum        out  [BD_NUM_WIDTH]  BD being requested / executed
//   opAck          in   engine accepts the request (looked at only in REQ)
//   opDone         in   engine finished the BD (looked at only in ACTIVE)
//   opComplete     out  one-cycle pulse: BD completeBdNum finished
//   completeBdNum  out  [BD_NUM_WIDTH]  index of the completed BD
//   pendingBDs     out  [NUM_INT_BDS]   queued-but-not-issued flags
//   busy           out  high while a BD is requested or executing
// ---------------------------------------------------------------------------
module dma_bd_start_scheduler #(
  parameter int NUM_INT_BDS  = 4,
  parameter int BD_NUM_WIDTH = 2
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [NUM_INT_BDS-1:0]  startDMAOp,
  output logic                    opReq,
  output logic [BD_NUM_WIDTH-1:0] opBdNum,
  input  logic                    opAck,
  input  logic                    opDone,
  output logic                    opComplete,
  output logic [BD_NUM_WIDTH-1:0] completeBdNum,
  output logic [NUM_INT_BDS-1:0]  pendingBDs,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  // After reset the pointer sits on the last BD so that the first search
  // starts at BD0.
  localparam logic [BD_NUM_WIDTH-1:0] LAST_BD = BD_NUM_WIDTH'(NUM_INT_BDS - 1);

  state_t                  state_q, state_d;
  logic [NUM_INT_BDS-1:0]  pending_q, pending_d;
  logic [BD_NUM_WIDTH-1:0] lastGrant_q, lastGrant_d;
  logic [BD_NUM_WIDTH-1:0] opBdNum_q, opBdNum_d;
  logic                    opComplete_q, opComplete_d;
  logic [BD_NUM_WIDTH-1:0] completeBdNum_q, completeBdNum_d;

  logic                    grantValid;
  logic [BD_NUM_WIDTH-1:0] grantIdx;
  logic [NUM_INT_BDS-1:0]  grantMask;

  // Round-robin pick. The first pass takes the lowest pending BD strictly
  // above the last grant; if there is none, the second pass wraps around
  // and takes the lowest pending BD overall. The wrap pass can return the
  // last-granted BD itself when it is the only one pending, which is what
  // lets a BD that was restarted during its own run go again.
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    for (int i = 0; i < NUM_INT_BDS; i++) begin
      if (!grantValid && pending_q[i] && (i > int'(lastGrant_q))) begin
        grantValid = 1'b1;
        grantIdx   = BD_NUM_WIDTH'(i);
      end
    end
    for (int i = 0; i < NUM_INT_BDS; i++) begin
      if (!grantValid && pending_q[i]) begin
        grantValid = 1'b1;
        grantIdx   = BD_NUM_WIDTH'(i);
      end
    end
  end

  assign grantMask = NUM_INT_BDS'(1) << grantIdx;

  // Next-state logic. New starts are OR-ed into the pending flags every
  // cycle. A start that arrives for a BD that is already pending therefore
  // merges with it. Because the OR is applied after the grant clear, a
  // start and a grant of the same BD in the same cycle leave the flag set.
  always_comb begin
    state_d         = state_q;
    pending_d       = pending_q | startDMAOp;
    lastGrant_d     = lastGrant_q;
    opBdNum_d       = opBdNum_q;
    opComplete_d    = 1'b0;
    completeBdNum_d = completeBdNum_q;

    unique case (state_q)
      IDLE: begin
        if (grantValid) begin
          state_d     = REQ;
          opBdNum_d   = grantIdx;
          lastGrant_d = grantIdx;
          pending_d   = (pending_q & ~grantMask) | startDMAOp;
        end
      end
      REQ: begin
        if (opAck) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (opDone) begin
          state_d         = IDLE;
          opComplete_d    = 1'b1;
          completeBdNum_d = opBdNum_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register. An asynchronous reset throws away everything,
  // including BDs that were queued or running, without a completion pulse.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q         <= IDLE;
      pending_q       <= '0;
      lastGrant_q     <= LAST_BD;
      opBdNum_q       <= '0;
      opComplete_q    <= 1'b0;
      completeBdNum_q <= '0;
    end else begin
      state_q         <= state_d;
      pending_q       <= pending_d;
      lastGrant_q     <= lastGrant_d;
      opBdNum_q       <= opBdNum_d;
      opComplete_q    <= opComplete_d;
      completeBdNum_q <= completeBdNum_d;
    end
  end

  // Every output is either a flop or a decode of the state flop only, so no
  // input reaches an output without passing through a register.
  assign opReq         = (state_q == REQ);
  assign busy          = (state_q != IDLE);
  assign opBdNum       = opBdNum_q;
  assign opComplete    = opComplete_q;
  assign completeBdNum = completeBdNum_q;
  assign pendingBDs    = pending_q;

endmodule

// File: tb/tb_dma_bd_start_scheduler.sv
// ---------------------------------------------------------------------------
// tb_dma_bd_start_scheduler
//
// Bench for dma_bd_start_scheduler with four BDs. The stimulus code pushes
// the issue/complete events it expects into a queue. A monitor pops the
// queue whenever the DUT raises opReq or pulses opComplete and compares the
// events. An optional engine model answers requests with configurable ack
// and done delays. Direct checks cover reset values, pending flags and
// stability while a request is held.
// ---------------------------------------------------------------------------
module tb_dma_bd_start_scheduler;

  localparam int NBD = 4;
  localparam int BW  = 2;

  logic           clock;
  logic           resetn;
  logic [NBD-1:0] startDMAOp;
  logic           opReq;
  logic [BW-1:0]  opBdNum;
  logic           opAck;
  logic           opDone;
  logic           opComplete;
  logic [BW-1:0]  completeBdNum;
  logic [NBD-1:0] pendingBDs;
  logic           busy;

  logic engAck, engDone, manAck, manDone;
  assign opAck  = engAck | manAck;
  assign opDone = engDone | manDone;

  typedef struct {
    bit isComplete;
    int idx;
  } ev_t;

  ev_t expQ[$];

  int  compared   = 0;
  int  mismatched = 0;

  bit  autoEngine = 0;
  int  ackWait    = 0;
  int  doneWait   = 0;
  bit  prevReq    = 0;

  dma_bd_start_scheduler #(
    .NUM_INT_BDS (NBD),
    .BD_NUM_WIDTH(BW)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .startDMAOp   (startDMAOp),
    .opReq        (opReq),
    .opBdNum      (opBdNum),
    .opAck        (opAck),
    .opDone       (opDone),
    .opComplete   (opComplete),
    .completeBdNum(completeBdNum),
    .pendingBDs   (pendingBDs),
    .busy         (busy)
  );

  // Free-running clock, 10 time units per cycle.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard time limit so the run always ends, even if the DUT hangs.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point used by both the stimulus and the monitor.
  task automatic checkOutput(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expectRun(input int idx);
    expQ.push_back('{isComplete: 1'b0, idx: idx});
    expQ.push_back('{isComplete: 1'b1, idx: idx});
  endtask

  // Monitor: samples on the falling edge. A rising opReq or a high
  // opComplete consumes the next expected event.
  always @(negedge clock) begin
    if (!resetn) begin
      prevReq <= 1'b0;
    end else begin
      if (opReq && !prevReq) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected issue", int'(opBdNum), -1);
        end else begin
          ev_t e;
          e = expQ.pop_front();
          checkOutput("issue kind", 0, int'(e.isComplete));
          checkOutput("issue bd", int'(opBdNum), e.idx);
        end
      end
      if (opComplete) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected complete", int'(completeBdNum), -1);
        end else begin
          ev_t e;
          e = expQ.pop_front();
          checkOutput("complete kind", 1, int'(e.isComplete));
          checkOutput("complete bd", int'(completeBdNum), e.idx);
        end
      end
      prevReq <= opReq;
    end
  end

  // Engine model: once it sees a request it waits ackWait cycles, acks
  // for one cycle, waits doneWait cycles, then strobes done for one cycle.
  initial begin
    engAck  = 1'b0;
    engDone = 1'b0;
    forever begin
      @(negedge clock);
      if (autoEngine && resetn && opReq) begin
        repeat (ackWait) @(negedge clock);
        engAck = 1'b1;
        @(negedge clock);
        engAck = 1'b0;
        repeat (doneWait) @(negedge clock);
        engDone = 1'b1;
        @(negedge clock);
        engDone = 1'b0;
      end
    end
  end

  // One-cycle start pulse driven between clock edges.
  task automatic applyStimulus(input logic [NBD-1:0] v);
    @(negedge clock);
    startDMAOp = v;
    @(negedge clock);
    startDMAOp = '0;
  endtask

  task automatic doReset();
    @(negedge clock);
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic waitReq(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!opReq && n < 60);
    if (!opReq) checkOutput({name, " req timeout"}, 0, 1);
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while ((expQ.size() != 0 || busy) && n < 400) begin
      @(negedge clock);
      n++;
    end
    checkOutput({name, " drained"}, expQ.size(), 0);
    expQ.delete();
  endtask

  task automatic pulseAck();
    @(negedge clock);
    manAck = 1'b1;
    @(negedge clock);
    manAck = 1'b0;
  endtask

  task automatic pulseDone();
    @(negedge clock);
    manDone = 1'b1;
    @(negedge clock);
    manDone = 1'b0;
  endtask

  initial begin
    resetn     = 1'b0;
    startDMAOp = '0;
    manAck     = 1'b0;
    manDone    = 1'b0;
    repeat (2) @(negedge clock);

    // Reset values.
    checkOutput("rst opReq",         int'(opReq), 0);
    checkOutput("rst opBdNum",       int'(opBdNum), 0);
    checkOutput("rst opComplete",    int'(opComplete), 0);
    checkOutput("rst completeBdNum", int'(completeBdNum), 0);
    checkOutput("rst pendingBDs",    int'(pendingBDs), 0);
    checkOutput("rst busy",          int'(busy), 0);
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    // Single start on BD2 with a manually driven engine.
    expectRun(2);
    applyStimulus(4'b0100);
    checkOutput("t1 pending after pulse", int'(pendingBDs), 4'b0100);
    checkOutput("t1 opReq not yet",       int'(opReq), 0);
    @(negedge clock);
    checkOutput("t1 opReq",       int'(opReq), 1);
    checkOutput("t1 opBdNum",     int'(opBdNum), 2);
    checkOutput("t1 pending clr", int'(pendingBDs), 0);
    checkOutput("t1 busy",        int'(busy), 1);
    manAck = 1'b1;
    @(negedge clock);
    manAck = 1'b0;
    checkOutput("t1 active opReq", int'(opReq), 0);
    checkOutput("t1 active busy",  int'(busy), 1);
    manDone = 1'b1;
    @(negedge clock);
    manDone = 1'b0;
    checkOutput("t1 complete pulse", int'(opComplete), 1);
    checkOutput("t1 idle busy",      int'(busy), 0);
    @(negedge clock);
    checkOutput("t1 complete one cycle", int'(opComplete), 0);
    waitDrain("t1");

    // All four BDs at once after reset: served 0,1,2,3.
    doReset();
    ackWait    = 0;
    doneWait   = 0;
    autoEngine = 1;
    for (int i = 0; i < NBD; i++) expectRun(i);
    applyStimulus(4'b1111);
    waitDrain("t2");

    // BD1 running; BD3 and BD0 arrive meanwhile -> 3 then 0.
    ackWait  = 3;
    doneWait = 2;
    expectRun(1);
    expectRun(3);
    expectRun(0);
    applyStimulus(4'b0010);
    waitReq("t3");
    applyStimulus(4'b1001);
    waitDrain("t3");

    // Restart of BD1 while it is executing -> BD1 runs twice.
    ackWait  = 0;
    doneWait = 6;
    expectRun(1);
    expectRun(1);
    applyStimulus(4'b0010);
    waitReq("t4a");
    applyStimulus(4'b0010);
    waitDrain("t4a");

    // Duplicate start on a pending BD2 while BD3 runs -> BD2 once.
    expectRun(3);
    expectRun(2);
    applyStimulus(4'b1000);
    waitReq("t4b");
    applyStimulus(4'b0100);
    applyStimulus(4'b0100);
    checkOutput("t4b merged pending", int'(pendingBDs), 4'b0100);
    waitDrain("t4b");
    repeat (10) @(negedge clock);
    checkOutput("t4b idle busy",    int'(busy), 0);
    checkOutput("t4b idle pending", int'(pendingBDs), 0);

    // Held request, stray opDone in REQ and stray opAck in ACTIVE.
    autoEngine = 0;
    @(negedge clock);
    expectRun(0);
    applyStimulus(4'b0001);
    waitReq("t5");
    for (int c = 0; c < 10; c++) begin
      manDone = (c == 3);
      @(negedge clock);
      checkOutput("t5 held opReq",   int'(opReq), 1);
      checkOutput("t5 held opBdNum", int'(opBdNum), 0);
    end
    manDone = 1'b0;
    pulseAck();
    checkOutput("t5 active opReq", int'(opReq), 0);
    pulseAck();
    checkOutput("t5 stray ack busy",     int'(busy), 1);
    checkOutput("t5 stray ack opReq",    int'(opReq), 0);
    checkOutput("t5 stray ack complete", int'(opComplete), 0);
    pulseDone();
    waitDrain("t5");

    // Reset while BD2 is executing with BD1 and BD3 pending.
    expQ.push_back('{isComplete: 1'b0, idx: 2});
    applyStimulus(4'b0100);
    waitReq("t6");
    pulseAck();
    applyStimulus(4'b1010);
    checkOutput("t6 pending before rst", int'(pendingBDs), 4'b1010);
    checkOutput("t6 active before rst",  int'(busy), 1);
    checkOutput("t6 queue before rst",   expQ.size(), 0);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("t6 rst opReq",         int'(opReq), 0);
    checkOutput("t6 rst opBdNum",       int'(opBdNum), 0);
    checkOutput("t6 rst opComplete",    int'(opComplete), 0);
    checkOutput("t6 rst completeBdNum", int'(completeBdNum), 0);
    checkOutput("t6 rst pendingBDs",    int'(pendingBDs), 0);
    checkOutput("t6 rst busy",          int'(busy), 0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (4) @(negedge clock);
    checkOutput("t6 after rst busy", int'(busy), 0);
    ackWait    = 1;
    doneWait   = 1;
    autoEngine = 1;
    expectRun(0);
    applyStimulus(4'b0001);
    waitDrain("t6");
    repeat (4) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dma_bd_start_scheduler.md
# dma_bd_start_scheduler

Queues the one-cycle per-descriptor start pulses from the DMA control-register block and issues them one at a time to the DMA transfer engine. Round-robin arbitration over internal buffer descriptors (BDs), a request/acknowledge handshake on issue, and a done handshake on completion. Sits between the control-register block's `startDMAOp` output and the engine's descriptor-fetch/dispatch input.

## Interface

- NUM_INT_BDS, 4, number of internal BDs (1..32)
- BD_NUM_WIDTH, 2, width of BD index; NUM_INT_BDS <= 2**BD_NUM_WIDTH
- clock  in  1  clock
- resetn  in  1  reset; asynchronous, active-low
- startDMAOp  in  NUM_INT_BDS  one-cycle start pulses, bit n = BD n; multiple bits may be set in one cycle
- opReq  out  1  request to engine: execute BD opBdNum
- opBdNum  out  BD_NUM_WIDTH  BD index being requested or executed
- opAck  in  1  engine accepts request; sampled only in REQ
- opDone  in  1  engine finished current BD; sampled only in ACTIVE
- opComplete  out  1  one-cycle pulse: BD completeBdNum finished
- completeBdNum  out  BD_NUM_WIDTH  index of completed BD, valid with opComplete
- pendingBDs  out  NUM_INT_BDS  queued-but-not-issued BD flags
- busy  out  1  high in REQ or ACTIVE

## Operation

- Pending register: bit n set on `startDMAOp[n]`; cleared only when BD n is granted. Start on an already-pending BD merges (no second entry).
- Start on the BD currently in REQ/ACTIVE sets its pending bit: BD re-runs after the current run completes.
- Start and grant of the same BD in the same cycle: set wins (bit ends 1).
- FSM states: IDLE, REQ, ACTIVE.
  - IDLE: if pendingBDs != 0, grant per round-robin, register opBdNum, clear that pending bit, go to REQ. Else stay.
  - REQ: opReq=1; opBdNum held stable. On opAck go to ACTIVE (opReq low from next cycle).
  - ACTIVE: on opDone pulse opComplete with completeBdNum=opBdNum, go to IDLE.
- Round-robin: pointer lastGrant, reset to NUM_INT_BDS-1 (BD0 highest priority first). Search lastGrant+1 upward, wrapping at NUM_INT_BDS-1 -> 0. lastGrant updates on each grant.
- opAck outside REQ and opDone outside ACTIVE are ignored.
- opDone and opAck are single-cycle qualifiers; engine must not assert opDone in the same cycle as opAck (ACTIVE lasts at least 1 cycle).
- Bits of startDMAOp at index >= NUM_INT_BDS do not exist; opBdNum never exceeds NUM_INT_BDS-1.

## Timing

- Reset values: opReq 0, opBdNum 0, opComplete 0, completeBdNum 0, pendingBDs 0, busy 0, state IDLE, lastGrant NUM_INT_BDS-1.
- Reset mid-operation: all state and pending flags discarded immediately; no opComplete emitted.
- Start pulse at edge t: pendingBDs bit visible after t; opReq high after t+1 (2-cycle latency from IDLE).
- opReq and opAck high at same edge: transfer accepted; busy stays high, opReq low next cycle.
- opDone at edge t: opComplete high for cycle after t; state IDLE after t; next opReq after t+1 if anything is pending (one IDLE bubble minimum between issues).
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan

- Reset, single start on BD2 -> pendingBDs=4'b0100 one cycle, opReq=1 opBdNum=2 two cycles after pulse; opAck, opDone -> opComplete one cycle with completeBdNum=2, pendingBDs=0, busy=0.
- startDMAOp=4'b1111 in one cycle -> issue order 0,1,2,3, each followed by opComplete with matching index.
- BD1 running, then starts on BD3 and BD0 -> after done of BD1, order is 3 then 0 (round-robin from lastGrant=1).
- Start BD1 while BD1 ACTIVE -> after opComplete(1), BD1 issued again; duplicate start on pending BD2 -> BD2 runs exactly once.
- Hold opAck low 10 cycles in REQ -> opReq and opBdNum stable throughout; stray opDone in REQ and stray opAck in ACTIVE ignored.
- Assert resetn low while ACTIVE with pending 4'b1010 -> all outputs at reset values; no opComplete; first grant after release is BD0 when restarted with 4'b0001.
